// File: rtl/ctrl_seq_if.sv
// rtl/ctrl_seq_if.sv - select lines and memory handshake between ctrl_seq and the memory controller/datapath
interface ctrl_seq_if #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int REG_SEL_WIDTH  = 2
);
  logic [1:0]                mem_ctrl_op;
  logic [1:0]                addr_reg_op;
  logic                      addr_sel;
  logic [2:0]                alu_op;
  logic                      reg_op;
  logic [REG_SEL_WIDTH-1:0]  reg_sel_in;
  logic [REG_SEL_WIDTH-1:0]  reg_sel_1;
  logic [REG_SEL_WIDTH-1:0]  reg_sel_2;
  logic [1:0]                mux_sel;
  logic [DATA_BUS_WIDTH-1:0] bus_data_in;
  logic                      mem_op_done;
  logic                      flag_zero;
  logic                      flag_carry;

  modport master (
    output mem_ctrl_op, addr_reg_op, addr_sel, alu_op, reg_op,
           reg_sel_in, reg_sel_1, reg_sel_2, mux_sel,
    input  bus_data_in, mem_op_done, flag_zero, flag_carry
  );

  modport slave (
    input  mem_ctrl_op, addr_reg_op, addr_sel, alu_op, reg_op,
           reg_sel_in, reg_sel_1, reg_sel_2, mux_sel,
    output bus_data_in, mem_op_done, flag_zero, flag_carry
  );
endinterface

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - multi-cycle fetch/decode/execute sequencer with memory-wait timeout and halt/resume
module ctrl_seq #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int REG_SEL_WIDTH  = 2,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       resume,
  output logic       halted,
  output logic       fault,
  ctrl_seq_if.master bus
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_HALT   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;
  localparam logic [1:0] ADDR_INC  = 2'd1;
  localparam logic [1:0] ADDR_LOAD = 2'd2;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [2:0]                state, state_next;
  logic [DATA_BUS_WIDTH-1:0] ir;
  logic [CW-1:0]             tmo_cnt;
  logic                      exec_first;
  logic                      cond_q;
  logic                      cond_now;
  logic                      waiting;
  logic                      timeout_hit;

  logic [3:0]               op;
  logic [REG_SEL_WIDTH-1:0] rd, rs;

  assign op = ir[DATA_BUS_WIDTH-1 -: 4];
  assign rd = ir[2*REG_SEL_WIDTH-1 -: REG_SEL_WIDTH];
  assign rs = ir[REG_SEL_WIDTH-1:0];

  // Jump condition is frozen on the first EXEC cycle so a flag change during the wait has no effect.
  assign cond_now = exec_first ? ((op == OP_JZ) ? bus.flag_zero : bus.flag_carry) : cond_q;

  assign timeout_hit = (MEM_TIMEOUT != 0) && ((int'(tmo_cnt) + 1) >= MEM_TIMEOUT);

  always_comb begin
    bus.mem_ctrl_op = MEM_NOP;
    bus.addr_reg_op = 2'd0;
    bus.addr_sel    = 1'b0;
    bus.alu_op      = 3'd0;
    bus.reg_op      = 1'b0;
    bus.reg_sel_in  = '0;
    bus.reg_sel_1   = '0;
    bus.reg_sel_2   = '0;
    bus.mux_sel     = 2'd0;
    halted          = 1'b0;
    fault           = 1'b0;
    waiting         = 1'b0;
    state_next      = state;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          bus.mem_ctrl_op = MEM_READ;
          waiting         = 1'b1;
          if (bus.mem_op_done) begin
            bus.addr_reg_op = ADDR_INC;
            state_next      = S_DECODE;
          end
        end
        S_DECODE: state_next = S_EXEC;
        S_EXEC: begin
          state_next = S_FETCH;
          case (op)
            OP_MOV: begin
              bus.reg_sel_2  = rs;
              bus.reg_sel_in = rd;
              bus.reg_op     = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              bus.alu_op     = op[2:0] - 3'd1;
              bus.reg_sel_1  = rd;
              bus.reg_sel_2  = rs;
              bus.reg_sel_in = rd;
              bus.reg_op     = 1'b1;
            end
            OP_LDI: begin
              bus.mem_ctrl_op = MEM_READ;
              waiting         = 1'b1;
              if (bus.mem_op_done) begin
                bus.reg_op      = 1'b1;
                bus.mux_sel     = 2'd1;
                bus.reg_sel_in  = rd;
                bus.addr_reg_op = ADDR_INC;
              end
            end
            OP_LD: begin
              bus.mem_ctrl_op = MEM_READ;
              bus.addr_sel    = 1'b1;
              bus.reg_sel_2   = rs;
              waiting         = 1'b1;
              if (bus.mem_op_done) begin
                bus.reg_op     = 1'b1;
                bus.mux_sel    = 2'd1;
                bus.reg_sel_in = rd;
              end
            end
            OP_ST: begin
              bus.mem_ctrl_op = MEM_WRITE;
              bus.addr_sel    = 1'b1;
              bus.reg_sel_2   = rs;
              bus.reg_sel_1   = rd;
              waiting         = 1'b1;
            end
            OP_JMP, OP_JZ, OP_JC: begin
              if (op == OP_JMP || cond_now) begin
                bus.mem_ctrl_op = MEM_READ;
                waiting         = 1'b1;
                if (bus.mem_op_done) bus.addr_reg_op = ADDR_LOAD;
              end else begin
                bus.addr_reg_op = ADDR_INC;
              end
            end
            OP_HLT:  state_next = S_HALT;
            default: ;
          endcase
        end
        S_HALT: begin
          halted = 1'b1;
          if (resume) state_next = S_FETCH;
        end
        S_FAULT: fault = 1'b1;
        default: state_next = S_FETCH;
      endcase
      // Any held memory access without completion either stays put or times out.
      if (waiting && !bus.mem_op_done) state_next = timeout_hit ? S_FAULT : state;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_FETCH;
      ir         <= '0;
      tmo_cnt    <= '0;
      exec_first <= 1'b0;
      cond_q     <= 1'b0;
    end else begin
      state      <= state_next;
      if (state == S_FETCH && bus.mem_op_done) ir <= bus.bus_data_in;
      tmo_cnt    <= (waiting && !bus.mem_op_done) ? tmo_cnt + CW'(1) : '0;
      exec_first <= (state == S_DECODE);
      cond_q     <= cond_now;
    end
  end
endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - directed self-checking bench for ctrl_seq
module tb_ctrl_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic resume = 1'b0;
  logic halted, fault;
  int   checks = 0;
  int   errors = 0;
  logic [18:0] got, e;

  ctrl_seq_if #(.DATA_BUS_WIDTH(8), .REG_SEL_WIDTH(2)) ifc ();

  ctrl_seq #(.DATA_BUS_WIDTH(8), .REG_SEL_WIDTH(2), .MEM_TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .resume(resume),
    .halted(halted),
    .fault (fault),
    .bus   (ifc.master)
  );

  always #5 clock = ~clock;

  function automatic logic [18:0] outs();
    return {ifc.mem_ctrl_op, ifc.addr_reg_op, ifc.addr_sel, ifc.alu_op, ifc.reg_op,
            ifc.reg_sel_in, ifc.reg_sel_1, ifc.reg_sel_2, ifc.mux_sel, halted, fault};
  endfunction

  function automatic logic [18:0] ev(input logic [1:0] m, input logic [1:0] a, input logic s,
                                     input logic [2:0] alu, input logic r, input logic [1:0] si,
                                     input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] mx,
                                     input logic h, input logic f);
    return {m, a, s, alu, r, si, s1, s2, mx, h, f};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [7:0] instr);
    ifc.bus_data_in = instr; ifc.mem_op_done = 1'b1; #1;
    e = ev(1,1,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL fetch_done %02h: got %05h expected %05h", instr, got, e); end
    tick(); ifc.mem_op_done = 1'b0; ifc.bus_data_in = 8'h00; #1;
    e = '0; got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL decode_idle %02h: got %05h expected %05h", instr, got, e); end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ifc.mem_op_done = 1'b1; ifc.bus_data_in = 8'hFF; ifc.flag_zero = 1'b0; ifc.flag_carry = 1'b0;
    tick(); #1;
    e = '0; got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_idle: got %05h expected %05h", got, e); end
    ifc.mem_op_done = 1'b0; tick();
    reset = 1'b0; #1;
    e = ev(1,0,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_fetch: got %05h expected %05h", got, e); end
  endtask

  task automatic test_add();
    fetch(8'h26); #1;
    e = ev(0,0,0,1,1,1,1,2,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL add_exec: got %05h expected %05h", got, e); end
    tick(); #1;
    e = ev(1,0,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL add_cycle4_fetch: got %05h expected %05h", got, e); end
  endtask

  task automatic test_alu_ops();
    logic [7:0] instr [4] = '{8'h31, 8'h4B, 8'h56, 8'h1B};
    logic [2:0] alu   [4] = '{3'd2, 3'd3, 3'd4, 3'd0};
    logic [1:0] s1    [4] = '{2'd0, 2'd2, 2'd1, 2'd0};
    logic [1:0] s2    [4] = '{2'd1, 2'd3, 2'd2, 2'd3};
    logic [1:0] si    [4] = '{2'd0, 2'd2, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      fetch(instr[i]); #1;
      e = ev(0,0,0,alu[i],1,si[i],s1[i],s2[i],0,0,0); got = outs(); checks++;
      if (got !== e) begin errors++; $display("FAIL alu_exec %02h: got %05h expected %05h", instr[i], got, e); end
      tick();
    end
  endtask

  task automatic test_ldi();
    fetch(8'h7C);
    for (int i = 0; i < 2; i++) begin
      #1; e = ev(1,0,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
      if (got !== e) begin errors++; $display("FAIL ldi_wait%0d: got %05h expected %05h", i, got, e); end
      tick();
    end
    ifc.bus_data_in = 8'hA5; ifc.mem_op_done = 1'b1; #1;
    e = ev(1,1,0,0,1,3,0,0,1,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL ldi_done: got %05h expected %05h", got, e); end
    tick(); ifc.mem_op_done = 1'b0; #1;
    e = ev(1,0,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL ldi_back_fetch: got %05h expected %05h", got, e); end
  endtask

  task automatic test_jumps();
    ifc.flag_zero = 1'b0;
    fetch(8'hB0); #1;
    e = ev(0,1,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL jz_not_taken: got %05h expected %05h", got, e); end
    tick(); #1;
    e = ev(1,0,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL jz_nt_fetch: got %05h expected %05h", got, e); end
    ifc.flag_zero = 1'b1;
    fetch(8'hB0); #1;
    e = ev(1,0,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL jz_taken_wait: got %05h expected %05h", got, e); end
    tick(); ifc.flag_zero = 1'b0; ifc.mem_op_done = 1'b1; #1;
    e = ev(1,2,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL jz_taken_load: got %05h expected %05h", got, e); end
    tick(); ifc.mem_op_done = 1'b0;
    ifc.flag_carry = 1'b1;
    fetch(8'hC0); ifc.mem_op_done = 1'b1; #1;
    e = ev(1,2,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL jc_taken_load: got %05h expected %05h", got, e); end
    tick(); ifc.mem_op_done = 1'b0; ifc.flag_carry = 1'b0;
  endtask

  task automatic test_timeout();
    int bad;
    fetch(8'h8D);
    for (int i = 0; i < 14; i++) tick();
    ifc.mem_op_done = 1'b1; #1;
    e = ev(1,0,1,0,1,3,0,1,1,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL ld_done_at_limit: got %05h expected %05h", got, e); end
    tick(); ifc.mem_op_done = 1'b0; #1;
    e = ev(1,0,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL ld_limit_fetch: got %05h expected %05h", got, e); end
    fetch(8'h8D);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      #1; if (outs() !== ev(1,0,1,0,0,0,0,1,0,0,0)) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ld_wait_cycles: got %0d bad cycles expected 0", bad); end
    for (int i = 0; i < 5; i++) begin
      #1; e = ev(0,0,0,0,0,0,0,0,0,0,1); got = outs(); checks++;
      if (got !== e) begin errors++; $display("FAIL fault_state%0d: got %05h expected %05h", i, got, e); end
      ifc.mem_op_done = 1'b1; resume = 1'b1; tick();
    end
    ifc.mem_op_done = 1'b0; resume = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; #1;
    e = ev(1,0,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL fault_cleared: got %05h expected %05h", got, e); end
  endtask

  task automatic test_halt();
    int bad;
    fetch(8'hF0); #1;
    e = '0; got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL hlt_exec_idle: got %05h expected %05h", got, e); end
    tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1; if (outs() !== ev(0,0,0,0,0,0,0,0,0,1,0)) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles expected 0", bad); end
    resume = 1'b1; tick(); resume = 1'b0; #1;
    e = ev(1,0,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL resume_fetch: got %05h expected %05h", got, e); end
    fetch(8'hF0); tick();
    resume = 1'b1; reset = 1'b1; #1;
    e = '0; got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_over_resume: got %05h expected %05h", got, e); end
    tick(); resume = 1'b0; reset = 1'b0; #1;
    e = ev(1,0,0,0,0,0,0,0,0,0,0); got = outs(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_resume_fetch: got %05h expected %05h", got, e); end
  endtask

  task automatic test_st_reset();
    int bad;
    fetch(8'h97);
    for (int i = 0; i < 2; i++) begin
      #1; e = ev(2,0,1,0,0,0,1,3,0,0,0); got = outs(); checks++;
      if (got !== e) begin errors++; $display("FAIL st_wait%0d: got %05h expected %05h", i, got, e); end
      tick();
    end
    reset = 1'b1; tick(); reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1; if (outs() !== ev(1,0,0,0,0,0,0,0,0,0,0)) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL st_abandoned: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    ifc.bus_data_in = 8'h00; ifc.mem_op_done = 1'b0; ifc.flag_zero = 1'b0; ifc.flag_carry = 1'b0;
    test_reset();
    test_add();
    test_alu_ops();
    test_ldi();
    test_jumps();
    test_timeout();
    test_halt();
    test_st_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end
endmodule
